// File: rtl/sram_wbqueue.sv
// Pipelined Wishbone request queue feeding a one-request-at-a-time async-SRAM controller.
// Requests are buffered, issued downstream serially, and acked upstream in request order.
module sram_wbqueue #(
  parameter int unsigned AW     = 15,
  parameter int unsigned DW     = 32,
  parameter int unsigned LGFIFO = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  // Upstream (bus master side)
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [DW-1:0]   o_wb_data,
  // Downstream (SRAM controller side)
  output logic            o_dn_cyc,
  output logic            o_dn_stb,
  output logic            o_dn_we,
  output logic [AW-1:0]   o_dn_addr,
  output logic [DW-1:0]   o_dn_data,
  output logic [DW/8-1:0] o_dn_sel,
  input  logic            i_dn_stall,
  input  logic            i_dn_ack,
  input  logic [DW-1:0]   i_dn_data
);

  localparam int unsigned SW    = DW / 8;
  localparam int unsigned FW    = 1 + AW + DW + SW;
  localparam int unsigned Depth = 1 << LGFIFO;
  localparam int unsigned CW    = LGFIFO + 1;

  localparam logic [LGFIFO-1:0] PtrOne  = LGFIFO'(1);
  localparam logic [CW-1:0]     CntOne  = CW'(1);
  localparam logic [CW-1:0]     CntFull = CW'(Depth);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDrain
  } state_e;

  state_e            state_q;
  logic [FW-1:0]     mem_q [Depth];
  logic [LGFIFO-1:0] wr_ptr_q;
  logic [LGFIFO-1:0] rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic              push;
  logic              pop;
  logic [FW-1:0]     head;

  assign o_wb_stall = (count_q == CntFull) || (state_q == StDrain);
  assign push       = i_wb_cyc && i_wb_stb && !o_wb_stall;
  // Only the idle state pulls from the queue, so one downstream request is ever outstanding.
  assign pop        = (state_q == StIdle) && i_wb_cyc && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_wb_we, i_wb_addr, i_wb_data, i_wb_sel};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      o_wb_ack <= 1'b0;
      o_dn_cyc <= 1'b0;
      o_dn_stb <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;

      // A dropped CYC discards everything still queued.
      if (!i_wb_cyc) begin
        rd_ptr_q <= wr_ptr_q;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrOne;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrOne;
        end
        if (push && !pop) begin
          count_q <= count_q + CntOne;
        end else if (pop && !push) begin
          count_q <= count_q - CntOne;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            {o_dn_we, o_dn_addr, o_dn_data, o_dn_sel} <= head;
            o_dn_cyc <= 1'b1;
            o_dn_stb <= 1'b1;
            state_q  <= StIssue;
          end else begin
            o_dn_cyc <= 1'b0;
          end
        end

        StIssue: begin
          if (!i_wb_cyc) begin
            o_dn_cyc <= 1'b0;
            o_dn_stb <= 1'b0;
            state_q  <= StDrain;
          end else if (!i_dn_stall) begin
            o_dn_stb <= 1'b0;
            state_q  <= StWait;
          end
        end

        StWait: begin
          if (!i_wb_cyc) begin
            // An ack arriving with the abort belongs to discarded work.
            o_dn_cyc <= 1'b0;
            o_dn_stb <= 1'b0;
            state_q  <= StDrain;
          end else if (i_dn_ack) begin
            o_wb_ack  <= 1'b1;
            o_wb_data <= i_dn_data;
            o_dn_cyc  <= (count_q != '0);
            state_q   <= StIdle;
          end
        end

        StDrain: begin
          o_dn_cyc <= 1'b0;
          o_dn_stb <= 1'b0;
          if (!i_dn_stall && !i_dn_ack) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
